ct_vfalu_dp_pipex_wb: RTL and testbench
=======================================

Name: ct_vfalu_dp_pipex_wb

Overview:
- Parametrised writeback/forward datapath for a vector FP ALU pipe.
- Generalises the fixed two-source (fadd/fspu) result mux to N_SRC execution sources of DATA_W bits.
- Adds a registered EX4 writeback queue with valid/ready handshake to the register-file write port, EX3 backpressure, and sticky protocol-error flags.
- Sits between the VFALU execution units and the VFPU register-file/forwarding network, one instance per pipe.

Parameters:
- N_SRC, 2, number of execution sources (fadd, fspu, ...); legal range 2..8.
- DATA_W, 64, freg/mfvr data width.
- EREG_W, 5, exception-flag (ereg) width.
- DEPTH, 2, writeback queue entries; power of two, at least 2.

Ports:
- forever_cpuclk  in  1  core clock.
- cpurst  in  1  reset, synchronous, active-high.
- dp_vfalu_ex1_pipex_sel  in  N_SRC  EX1 one-hot mfvr source select.
- src_mfvr_data  in  N_SRC*DATA_W  per-source mfvr data; source i occupies bits [i*DATA_W +: DATA_W].
- pipex_dp_ex1_vfalu_mfvr_data  out  DATA_W  EX1 mfvr result.
- src_fwd_vld  in  N_SRC  EX3 per-source result valid.
- src_fwd_data  in  N_SRC*DATA_W  EX3 per-source result.
- src_ereg_vld  in  N_SRC  EX3 per-source ereg valid.
- src_ereg_data  in  N_SRC*EREG_W  EX3 per-source exception flags.
- pipex_dp_ex3_vfalu_freg_data  out  DATA_W  EX3 forwarded result (combinational).
- pipex_dp_ex3_vfalu_ereg_data  out  EREG_W  EX3 forwarded ereg (combinational).
- pipex_dp_ex3_stall  out  1  queue full; upstream must hold EX3.
- pipex_wb_vld  out  1  EX4 writeback valid.
- pipex_wb_data  out  DATA_W  writeback data.
- pipex_wb_ereg  out  EREG_W  writeback ereg.
- rf_pipex_wb_ready  in  1  register file accepts writeback.
- pipex_multi_hit_err  out  1  sticky: more than one src_fwd_vld in one cycle.
- pipex_overflow_err  out  1  sticky: push dropped while queue full.

Behaviour:
- Clock and reset: one clock, forever_cpuclk; cpurst is synchronous and active-high.
- Reset: queue empty, pointers 0, pipex_wb_vld=0, both error flags 0. Queue data storage is not reset.
- EX1 mfvr output:
  - Combinational OR of (sel[i] replicated across DATA_W) AND src_mfvr_data[i].
  - sel all-zero gives 0.
  - sel multi-hot gives the OR of the selected sources; this is legal and not flagged.
- EX3 forward:
  - Priority select, lowest index with src_fwd_vld set wins.
  - No valid source: freg output is 0. The output is never X.
  - ereg output: ereg data of the winning index, ANDed with that index's src_ereg_vld; 0 if no source is valid.
- Push:
  - push = |src_fwd_vld.
  - The entry stores {winning freg data, winning ereg}.
- Pop: pop = pipex_wb_vld & rf_pipex_wb_ready.
- Outputs from the queue:
  - pipex_wb_vld = queue not empty.
  - wb_data and wb_ereg come directly from the head entry register, so writeback latency is 1 cycle from EX3 when the queue is empty.
  - Data must stay stable while vld=1 and ready=0.
- Backpressure:
  - pipex_dp_ex3_stall = full. It is registered-state-only and does not depend on the current cycle's pop.
- Boundary cases:
  - Full with push and pop in the same cycle: push accepted, occupancy unchanged, no error.
  - Full with push and no pop: push dropped, pipex_overflow_err set and held until reset.
  - Empty with push and ready=1: the entry is visible next cycle and popped on that cycle's handshake. There is no same-cycle bypass.
- Errors:
  - Two or more src_fwd_vld bits set: pipex_multi_hit_err set (registered, visible next cycle) and held until reset. The lowest-index result is still pushed.
- Pointers: DEPTH is a power of two, so pointers wrap naturally. Occupancy counter width is clog2(DEPTH)+1.
- Reset mid-operation: all queued entries are discarded and vld=0 the next cycle, regardless of ready.

Decomposition:
- Shared package ct_vfalu_pkg holds:
  - the default localparams VFALU_DATA_W=64, VFALU_EREG_W=5;
  - a one-hot priority-encode function returning index and hit;
  - a multi-hit detect function (popcount greater than 1).
- One sub-module, ct_vfalu_wb_fifo (DEPTH x (DATA_W+EREG_W), valid/ready out, full/empty), instantiated once.
- The select logic stays in the top module.

Test Plan:
- Single source: src_fwd_vld=2'b10, src1 data=64'hDEAD_BEEF_0000_0001, ereg vld=1, ereg=5'h04, ready=1 -> same cycle freg_data=DEAD_BEEF_0000_0001; next cycle wb_vld=1, wb_data identical, wb_ereg=5'h04.
- Multi-hit: src_fwd_vld=2'b11, src0=64'h1, src1=64'h2 -> freg_data=64'h1; multi_hit_err=1 next cycle and stays 1 after 10 idle cycles.
- Backpressure: ready=0 with pushes 64'hA then 64'hB (DEPTH=2) -> stall=1; wb_data holds 64'hA stable. Raise ready -> pops A then B on consecutive cycles; stall drops after the first pop.
- Full with simultaneous push/pop: queue full, ready=1, push 64'hC -> no overflow; the output sequence is A, B, C in order.
- Overflow and reset: full, ready=0, push 64'hD -> overflow_err=1 and D never appears on wb_data. Assert cpurst for 1 cycle -> wb_vld=0 and both error flags 0 the next cycle.
- mfvr select with N_SRC=4: sel=4'b0100, src2=64'h55 -> mfvr_data=64'h55; sel=0 -> 0.

Source files
------------

// File: rtl/ct_vfalu_pkg.sv
// Shared types and helpers for the VFALU writeback datapath.
// Source vectors are zero-padded to VFALU_MAX_SRC before being passed in.
package ct_vfalu_pkg;

  localparam int unsigned VFALU_DATA_W  = 64;
  localparam int unsigned VFALU_EREG_W  = 5;
  localparam int unsigned VFALU_MAX_SRC = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } prio_t;

  // Lowest set bit wins; the downward scan leaves the lowest index last.
  function automatic prio_t prio_enc(input logic [VFALU_MAX_SRC-1:0] vec);
    prio_t r;
    r = '0;
    for (int unsigned i = VFALU_MAX_SRC; i > 0; i--) begin
      if (vec[i-1]) begin
        r.hit = 1'b1;
        r.idx = 3'(i - 1);
      end
    end
    return r;
  endfunction

  function automatic logic multi_hit(input logic [VFALU_MAX_SRC-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < VFALU_MAX_SRC; i++) begin
      cnt += 32'(vec[i]);
    end
    return cnt > 1;
  endfunction

endpackage

// File: rtl/ct_vfalu_wb_fifo.sv
// Writeback queue: DEPTH x W entries with valid/ready on the read side.
// Head data comes straight from storage so it holds while ready is low.
module ct_vfalu_wb_fifo #(
  parameter int unsigned W     = 69,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         ready,
  output logic         vld,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          pop;
  logic          accept;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign vld     = ~empty;
  assign pop     = vld & ready;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign accept  = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ct_vfalu_dp_pipex_wb.sv
// VFALU pipe writeback/forward datapath: EX1 mfvr mux, EX3 priority forward,
// registered EX4 writeback queue with backpressure and sticky error flags.
module ct_vfalu_dp_pipex_wb
  import ct_vfalu_pkg::*;
#(
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned DATA_W = VFALU_DATA_W,
  parameter int unsigned EREG_W = VFALU_EREG_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic [N_SRC-1:0]        dp_vfalu_ex1_pipex_sel,
  input  logic [N_SRC*DATA_W-1:0] src_mfvr_data,
  output logic [DATA_W-1:0]       pipex_dp_ex1_vfalu_mfvr_data,
  input  logic [N_SRC-1:0]        src_fwd_vld,
  input  logic [N_SRC*DATA_W-1:0] src_fwd_data,
  input  logic [N_SRC-1:0]        src_ereg_vld,
  input  logic [N_SRC*EREG_W-1:0] src_ereg_data,
  output logic [DATA_W-1:0]       pipex_dp_ex3_vfalu_freg_data,
  output logic [EREG_W-1:0]       pipex_dp_ex3_vfalu_ereg_data,
  output logic                    pipex_dp_ex3_stall,
  output logic                    pipex_wb_vld,
  output logic [DATA_W-1:0]       pipex_wb_data,
  output logic [EREG_W-1:0]       pipex_wb_ereg,
  input  logic                    rf_pipex_wb_ready,
  output logic                    pipex_multi_hit_err,
  output logic                    pipex_overflow_err
);

  logic [VFALU_MAX_SRC-1:0] fwd_vld_pad;
  prio_t                    win;
  logic                     drop;
  logic                     empty;

  always_comb begin
    pipex_dp_ex1_vfalu_mfvr_data = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      pipex_dp_ex1_vfalu_mfvr_data |= src_mfvr_data[i*DATA_W +: DATA_W]
                                      & {DATA_W{dp_vfalu_ex1_pipex_sel[i]}};
    end
  end

  assign fwd_vld_pad = VFALU_MAX_SRC'(src_fwd_vld);
  assign win         = prio_enc(fwd_vld_pad);

  always_comb begin
    pipex_dp_ex3_vfalu_freg_data = '0;
    pipex_dp_ex3_vfalu_ereg_data = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (win.hit && win.idx == 3'(i)) begin
        pipex_dp_ex3_vfalu_freg_data = src_fwd_data[i*DATA_W +: DATA_W];
        pipex_dp_ex3_vfalu_ereg_data = src_ereg_data[i*EREG_W +: EREG_W]
                                       & {EREG_W{src_ereg_vld[i]}};
      end
    end
  end

  ct_vfalu_wb_fifo #(
    .W     (DATA_W + EREG_W),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .push    (win.hit),
    .wr_data ({pipex_dp_ex3_vfalu_freg_data, pipex_dp_ex3_vfalu_ereg_data}),
    .ready   (rf_pipex_wb_ready),
    .vld     (pipex_wb_vld),
    .rd_data ({pipex_wb_data, pipex_wb_ereg}),
    .full    (pipex_dp_ex3_stall),
    .empty   (empty),
    .drop    (drop)
  );

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      pipex_multi_hit_err <= 1'b0;
      pipex_overflow_err  <= 1'b0;
    end else begin
      pipex_multi_hit_err <= pipex_multi_hit_err | multi_hit(fwd_vld_pad);
      pipex_overflow_err  <= pipex_overflow_err | drop;
    end
  end

endmodule

// File: tb/tb_ct_vfalu_dp_pipex_wb.sv
// Bench for ct_vfalu_dp_pipex_wb (N_SRC=4, DEPTH=2) against a queue-based model.
module tb_ct_vfalu_dp_pipex_wb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int EW = 5;
  localparam int DP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    sel;
  logic [N*DW-1:0] md;
  logic [N-1:0]    fv;
  logic [N*DW-1:0] fd;
  logic [N-1:0]    ev;
  logic [N*EW-1:0] ed;
  logic            ready;
  logic [DW-1:0]   mfvr, freg, wb_data;
  logic [EW-1:0]   ereg, wb_ereg;
  logic            stall, wb_vld, multi, ovf;

  logic [DW+EW-1:0] mq[$];
  logic             m_multi, m_ovf;
  int               passed = 0;
  int               total  = 0;

  always #5 clk = ~clk;

  ct_vfalu_dp_pipex_wb #(.N_SRC(N), .DATA_W(DW), .EREG_W(EW), .DEPTH(DP)) dut (
    .forever_cpuclk               (clk),
    .cpurst                       (rst),
    .dp_vfalu_ex1_pipex_sel       (sel),
    .src_mfvr_data                (md),
    .pipex_dp_ex1_vfalu_mfvr_data (mfvr),
    .src_fwd_vld                  (fv),
    .src_fwd_data                 (fd),
    .src_ereg_vld                 (ev),
    .src_ereg_data                (ed),
    .pipex_dp_ex3_vfalu_freg_data (freg),
    .pipex_dp_ex3_vfalu_ereg_data (ereg),
    .pipex_dp_ex3_stall           (stall),
    .pipex_wb_vld                 (wb_vld),
    .pipex_wb_data                (wb_data),
    .pipex_wb_ereg                (wb_ereg),
    .rf_pipex_wb_ready            (ready),
    .pipex_multi_hit_err          (multi),
    .pipex_overflow_err           (ovf)
  );

  function automatic int win_idx();
    for (int i = 0; i < N; i++) if (fv[i]) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] exp_freg();
    int w = win_idx();
    return (w < 0) ? '0 : fd[w*DW +: DW];
  endfunction

  function automatic logic [EW-1:0] exp_ereg();
    int w = win_idx();
    if (w < 0 || !ev[w]) return '0;
    return ed[w*EW +: EW];
  endfunction

  function automatic logic [DW-1:0] exp_mfvr();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < N; i++) if (sel[i]) r = r | md[i*DW +: DW];
    return r;
  endfunction

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    int w = win_idx();
    int nv = $countones(fv);
    logic [DW+EW-1:0] ent = {exp_freg(), exp_ereg()};
    bit do_pop  = (mq.size() > 0) && ready;
    bit do_push = (w >= 0) && ((mq.size() < DP) || do_pop);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_multi = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(ent);
      if (nv > 1) m_multi = 1'b1;
      if (w >= 0 && !do_push) m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    fv = '0; ev = '0; fd = '0; ed = '0; sel = '0; md = '0;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    fv = 4'b0001; ev = 4'b0001; fd = '0; ed = '0;
    fd[0 +: DW] = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); ready = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (wb_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", wb_vld); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
    total++; if (multi !== 1'b0) $display("FAIL reset_multi: got %b want 0", multi); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
    total++; if (freg !== '0) $display("FAIL reset_freg: got %h want 0", freg); else passed++;
  endtask

  task automatic test_mfvr();
    idle();
    sel = 4'b0100;
    for (int i = 0; i < N; i++) md[i*DW +: DW] = {$urandom(), $urandom()};
    md[2*DW +: DW] = 64'h55;
    #1;
    total++; if (mfvr !== 64'h55) $display("FAIL mfvr_sel2: got %h want 55", mfvr); else passed++;
    sel = '0; #1;
    total++; if (mfvr !== '0) $display("FAIL mfvr_zero: got %h want 0", mfvr); else passed++;
    for (int k = 0; k < 8; k++) begin
      sel = 4'($urandom());
      for (int i = 0; i < N; i++) md[i*DW +: DW] = {$urandom(), $urandom()};
      #1;
      total++; if (mfvr !== exp_mfvr()) $display("FAIL mfvr_rand: got %h want %h", mfvr, exp_mfvr()); else passed++;
    end
    idle();
  endtask

  task automatic test_single();
    ready = 1'b1;
    fv = 4'b0010; ev = 4'b0010;
    fd[DW +: DW] = 64'hDEAD_BEEF_0000_0001;
    ed[EW +: EW] = 5'h04;
    #1;
    total++; if (freg !== 64'hDEAD_BEEF_0000_0001) $display("FAIL single_freg: got %h want deadbeef00000001", freg); else passed++;
    total++; if (ereg !== 5'h04) $display("FAIL single_ereg: got %h want 04", ereg); else passed++;
    tick();
    idle();
    total++; if (wb_vld !== 1'b1) $display("FAIL single_wb_vld: got %b want 1", wb_vld); else passed++;
    total++; if (wb_data !== 64'hDEAD_BEEF_0000_0001) $display("FAIL single_wb_data: got %h want deadbeef00000001", wb_data); else passed++;
    total++; if (wb_ereg !== 5'h04) $display("FAIL single_wb_ereg: got %h want 04", wb_ereg); else passed++;
    tick();
    total++; if (wb_vld !== 1'b0) $display("FAIL single_drained: got %b want 0", wb_vld); else passed++;
  endtask

  task automatic test_multi_hit();
    ready = 1'b1;
    fv = 4'b0011; ev = '0;
    fd[0 +: DW] = 64'h1;
    fd[DW +: DW] = 64'h2;
    #1;
    total++; if (freg !== 64'h1) $display("FAIL multi_freg: got %h want 1", freg); else passed++;
    total++; if (multi !== 1'b0) $display("FAIL multi_before: got %b want 0", multi); else passed++;
    tick();
    idle();
    total++; if (multi !== 1'b1) $display("FAIL multi_set: got %b want 1", multi); else passed++;
    total++; if (wb_data !== 64'h1) $display("FAIL multi_wb_data: got %h want 1", wb_data); else passed++;
    for (int i = 0; i < 10; i++) tick();
    total++; if (multi !== 1'b1) $display("FAIL multi_sticky: got %b want 1", multi); else passed++;
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    push_one(64'hA);
    total++; if (stall !== 1'b0) $display("FAIL bp_stall_one: got %b want 0", stall); else passed++;
    push_one(64'hB);
    total++; if (stall !== 1'b1) $display("FAIL bp_stall_full: got %b want 1", stall); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (wb_data !== 64'hA || wb_vld !== 1'b1) $display("FAIL bp_hold: got %b/%h want 1/a", wb_vld, wb_data); else passed++;
    end
    ready = 1'b1;
    tick();
    total++; if (wb_data !== 64'hB) $display("FAIL bp_pop_b: got %h want b", wb_data); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL bp_stall_drop: got %b want 0", stall); else passed++;
    tick();
    total++; if (wb_vld !== 1'b0) $display("FAIL bp_empty: got %b want 0", wb_vld); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] want [3] = '{64'hA, 64'hB, 64'hC};
    ready = 1'b0;
    push_one(64'hA);
    push_one(64'hB);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (wb_vld !== 1'b1 || wb_data !== want[i]) $display("FAIL fpp_order%0d: got %b/%h want 1/%h", i, wb_vld, wb_data, want[i]); else passed++;
      if (i == 0) push_one(64'hC); else tick();
      if (i == 0) begin
        total++; if (stall !== 1'b1) $display("FAIL fpp_still_full: got %b want 1", stall); else passed++;
      end
    end
    total++; if (ovf !== 1'b0) $display("FAIL fpp_no_ovf: got %b want 0", ovf); else passed++;
    total++; if (wb_vld !== 1'b0) $display("FAIL fpp_empty: got %b want 0", wb_vld); else passed++;
  endtask

  task automatic test_overflow_reset();
    ready = 1'b0;
    push_one(64'hA);
    push_one(64'hB);
    push_one(64'hD);
    total++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else passed++;
    total++; if (wb_data !== 64'hA) $display("FAIL ovf_head: got %h want a", wb_data); else passed++;
    ready = 1'b1;
    tick();
    total++; if (wb_data !== 64'hB) $display("FAIL ovf_second: got %h want b", wb_data); else passed++;
    tick();
    total++; if (wb_vld !== 1'b0) $display("FAIL ovf_no_d: got %b/%h want 0", wb_vld, wb_data); else passed++;
    ready = 1'b0;
    push_one(64'hE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (wb_vld !== 1'b0) $display("FAIL rst_mid_vld: got %b want 0", wb_vld); else passed++;
    total++; if (ovf !== 1'b0 || multi !== 1'b0) $display("FAIL rst_mid_flags: got %b%b want 00", ovf, multi); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      sel = 4'($urandom());
      for (int i = 0; i < N; i++) begin
        md[i*DW +: DW] = {$urandom(), $urandom()};
        fd[i*DW +: DW] = {$urandom(), $urandom()};
      end
      ed = 20'($urandom());
      ev = 4'($urandom());
      fv = ($urandom_range(0, 2) == 0) ? '0 : 4'($urandom() & $urandom());
      ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 79) == 0);
      #1;
      total++; if (mfvr !== exp_mfvr()) $display("FAIL rnd_mfvr: got %h want %h", mfvr, exp_mfvr()); else passed++;
      total++; if (freg !== exp_freg() || ereg !== exp_ereg()) $display("FAIL rnd_fwd: got %h/%h want %h/%h", freg, ereg, exp_freg(), exp_ereg()); else passed++;
      tick();
      rst = 1'b0;
      total++; if (wb_vld !== (mq.size() > 0) || stall !== (mq.size() == DP)) $display("FAIL rnd_occ: got vld %b stall %b want occupancy %0d", wb_vld, stall, mq.size()); else passed++;
      total++; if (multi !== m_multi || ovf !== m_ovf) $display("FAIL rnd_flags: got %b%b want %b%b", multi, ovf, m_multi, m_ovf); else passed++;
      if (mq.size() > 0) begin
        total++; if ({wb_data, wb_ereg} !== mq[0]) $display("FAIL rnd_head: got %h/%h want %h", wb_data, wb_ereg, mq[0]); else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; ready = 1'b0; m_multi = 1'b0; m_ovf = 1'b0;
    idle();
    test_reset();
    test_mfvr();
    test_single();
    test_multi_hit();
    test_backpressure();
    test_full_push_pop();
    test_overflow_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
